// File: rtl/mlp_pkg.sv
// Shared types and per-state duration helpers for the MLP layer sequencer.
// The state encoding is visible on the sequencer's state output, so it must stay fixed.
package mlp_pkg;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_LOAD_WEIGHT  = 4'd1,
    S_LOAD_ACT     = 4'd2,
    S_COMPUTE      = 4'd3,
    S_DRAIN        = 4'd4,
    S_TRANSFER     = 4'd5,
    S_NEXT_LAYER   = 4'd6,
    S_WAIT_WEIGHTS = 4'd7,
    S_DONE         = 4'd8
  } state_e;

  function automatic int load_w_len(input int n);
    return n + 1;
  endfunction

  function automatic int load_act_len(input int n);
    return n + 2;
  endfunction

  function automatic int compute_len(input int nv, input int n);
    return nv + n - 1;
  endfunction

  function automatic int drain_len(input int n);
    return 2 * n + 3;
  endfunction

endpackage

// File: rtl/mlp_phase_counter.sv
// In-state cycle counter: clears whenever the owning FSM changes state,
// saturates at all-ones, and flags when it reaches the supplied terminal value.
module mlp_phase_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Multi-layer MLP control sequencer for an ARRAY_N x ARRAY_N systolic MMU.
// Optional performance counters are enabled with `define MLP_SEQ_PERF_CNT_EN.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int ARRAY_N     = 2,
  parameter int MAX_LAYERS  = 8,
  parameter int MAX_VEC     = 16,
  parameter int XFER_CYCLES = 4,
  parameter int DONE_HOLD   = 9,
  localparam int LAYER_W    = $clog2(MAX_LAYERS + 1),
  localparam int VEC_W      = $clog2(MAX_VEC + 1),
  localparam int CNT_W      = $clog2(MAX_VEC + 2 * ARRAY_N + 4)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic [VEC_W-1:0]   num_vectors,
  input  logic               weights_ready,
  output logic               weights_req,
  output logic               wf_pop,
  output logic [ARRAY_N-1:0] capture_col,
  output logic               ub_rd_ready,
  output logic               buffer_select,
  output logic               refill_en,
  output logic               mmu_valid,
  output logic               accum_en,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [LAYER_W-1:0] current_layer,
  output logic               layer_complete,
  output logic               busy,
  output logic               cfg_err,
  output logic               aborted
`ifdef MLP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_total_cycles,
  output logic [31:0]        perf_stall_cycles
`endif
);

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] nl_q, layer_q;
  logic [VEC_W-1:0]   nv_q;
  logic               bufsel_q, cfg_err_q, aborted_q;
  logic               cfg_ok, start_ok, tc, last_layer;
  logic [CNT_W-1:0]   term;

  assign cfg_ok = (int'(num_layers) >= 1) && (int'(num_layers) <= MAX_LAYERS) &&
                  (int'(num_vectors) >= 1) && (int'(num_vectors) <= MAX_VEC);
  assign start_ok   = (state_q == S_IDLE) && start && !abort && cfg_ok;
  assign last_layer = !((layer_q + LAYER_W'(1)) < nl_q);

  // Terminal count (duration - 1) for the timed states; untimed states ignore it.
  always_comb begin
    term = '0;
    case (state_q)
      S_LOAD_WEIGHT: term = CNT_W'(load_w_len(ARRAY_N) - 1);
      S_LOAD_ACT:    term = CNT_W'(load_act_len(ARRAY_N) - 1);
      S_COMPUTE:     term = CNT_W'(compute_len(int'(nv_q), ARRAY_N) - 1);
      S_DRAIN:       term = CNT_W'(drain_len(ARRAY_N) - 1);
      S_TRANSFER:    term = CNT_W'(XFER_CYCLES - 1);
      S_DONE:        term = CNT_W'(DONE_HOLD - 1);
      default:       term = '0;
    endcase
  end

  mlp_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i ((state_d != state_q) || (state_q == S_IDLE)),
    .term_i  (term),
    .cnt_o   (cycle_cnt),
    .tc_o    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort outranks every transition; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:         if (start_ok) state_d = S_LOAD_WEIGHT;
        S_LOAD_WEIGHT:  if (tc) state_d = (layer_q == '0) ? S_LOAD_ACT : S_COMPUTE;
        S_LOAD_ACT:     if (tc) state_d = S_COMPUTE;
        S_COMPUTE:      if (tc) state_d = S_DRAIN;
        S_DRAIN:        if (tc) state_d = last_layer ? S_DONE : S_TRANSFER;
        S_TRANSFER:     if (tc) state_d = S_NEXT_LAYER;
        S_NEXT_LAYER:   state_d = S_WAIT_WEIGHTS;
        S_WAIT_WEIGHTS: if (weights_ready) state_d = S_LOAD_WEIGHT;
        S_DONE:         if (tc) state_d = S_IDLE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    weights_req    = (state_q == S_WAIT_WEIGHTS);
    wf_pop         = (state_q == S_LOAD_WEIGHT);
    ub_rd_ready    = (state_q == S_COMPUTE) && (cycle_cnt < CNT_W'(nv_q));
    mmu_valid      = ((state_q == S_COMPUTE) && (cycle_cnt >= CNT_W'(ARRAY_N))) ||
                     (state_q == S_DRAIN);
    accum_en       = (state_q == S_DRAIN) && (cycle_cnt != '0);
    refill_en      = (state_q == S_DRAIN) || (state_q == S_TRANSFER);
    layer_complete = (state_q == S_DONE);
    busy           = (state_q != S_IDLE);
    capture_col    = '0;
    for (int k = 0; k < ARRAY_N; k++) begin
      capture_col[k] = (state_q == S_LOAD_WEIGHT) && (cycle_cnt == CNT_W'(k + 1));
    end
  end

  // Layer bookkeeping; an abort in NEXT_LAYER must not advance the layer.
  always_ff @(posedge clk) begin
    if (reset) begin
      nl_q      <= '0;
      nv_q      <= '0;
      layer_q   <= '0;
      bufsel_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == S_IDLE) && start && !abort && !cfg_ok;
      aborted_q <= abort && (state_q != S_IDLE);
      if (start_ok) begin
        nl_q     <= num_layers;
        nv_q     <= num_vectors;
        layer_q  <= '0;
        bufsel_q <= 1'b0;
      end else if ((state_q == S_NEXT_LAYER) && !abort) begin
        layer_q  <= layer_q + LAYER_W'(1);
        bufsel_q <= ~bufsel_q;
      end
    end
  end

  assign state         = state_q;
  assign current_layer = layer_q;
  assign buffer_select = bufsel_q;
  assign cfg_err       = cfg_err_q;
  assign aborted       = aborted_q;

`ifdef MLP_SEQ_PERF_CNT_EN
  logic [31:0] perf_total_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      perf_total_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((state_q != S_IDLE) && (perf_total_q != '1)) perf_total_q <= perf_total_q + 32'd1;
      if ((state_q == S_WAIT_WEIGHTS) && !weights_ready && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_total_cycles = perf_total_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: one ARRAY_N=2 and one ARRAY_N=4 instance share stimulus.
// Perf-counter checks are compiled in when MLP_SEQ_PERF_CNT_EN is defined.
module tb_mlp_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, weights_ready;
  logic [3:0] num_layers;
  logic [4:0] num_vectors;

  logic       weights_req2, wf_pop2, ub_rd_ready2, buffer_select2, refill_en2, mmu_valid2, accum_en2;
  logic       layer_complete2, busy2, cfg_err2, aborted2;
  logic [1:0] capture_col2;
  logic [3:0] state2, current_layer2;
  logic [4:0] cycle_cnt2;

  logic       weights_req4, wf_pop4, ub_rd_ready4, buffer_select4, refill_en4, mmu_valid4, accum_en4;
  logic       layer_complete4, busy4, cfg_err4, aborted4;
  logic [3:0] capture_col4;
  logic [3:0] state4, current_layer4;
  logic [4:0] cycle_cnt4;

`ifdef MLP_SEQ_PERF_CNT_EN
  logic [31:0] perf_total2, perf_stall2, perf_total4, perf_stall4;
`endif

  int   assertCount = 0;
  int   failCount = 0;
  logic rec2 = 1'b0;
  logic rec4 = 1'b0;
  int   runS2[$], runL2[$], runS4[$], runL4[$], bufQ4[$];
  logic [1:0] capQ2[$];
  int   mv2, ub2, rf2, lc2, wf2;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(.ARRAY_N(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_layers(num_layers), .num_vectors(num_vectors), .weights_ready(weights_ready),
    .weights_req(weights_req2), .wf_pop(wf_pop2), .capture_col(capture_col2),
    .ub_rd_ready(ub_rd_ready2), .buffer_select(buffer_select2), .refill_en(refill_en2),
    .mmu_valid(mmu_valid2), .accum_en(accum_en2), .state(state2), .cycle_cnt(cycle_cnt2),
    .current_layer(current_layer2), .layer_complete(layer_complete2), .busy(busy2),
    .cfg_err(cfg_err2), .aborted(aborted2)
`ifdef MLP_SEQ_PERF_CNT_EN
    , .perf_total_cycles(perf_total2), .perf_stall_cycles(perf_stall2)
`endif
  );

  mlp_layer_sequencer #(.ARRAY_N(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_layers(num_layers), .num_vectors(num_vectors), .weights_ready(weights_ready),
    .weights_req(weights_req4), .wf_pop(wf_pop4), .capture_col(capture_col4),
    .ub_rd_ready(ub_rd_ready4), .buffer_select(buffer_select4), .refill_en(refill_en4),
    .mmu_valid(mmu_valid4), .accum_en(accum_en4), .state(state4), .cycle_cnt(cycle_cnt4),
    .current_layer(current_layer4), .layer_complete(layer_complete4), .busy(busy4),
    .cfg_err(cfg_err4), .aborted(aborted4)
`ifdef MLP_SEQ_PERF_CNT_EN
    , .perf_total_cycles(perf_total4), .perf_stall_cycles(perf_stall4)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance to the next falling edge and log run-length state traces of both instances.
  task automatic tick();
    @(negedge clk);
    if (rec2 && state2 != 4'd0) begin
      if (runS2.size() == 0 || runS2[runS2.size()-1] != int'(state2)) begin
        runS2.push_back(int'(state2));
        runL2.push_back(1);
      end else begin
        runL2[runL2.size()-1] = runL2[runL2.size()-1] + 1;
      end
      mv2 += int'(mmu_valid2);
      ub2 += int'(ub_rd_ready2);
      rf2 += int'(refill_en2);
      lc2 += int'(layer_complete2);
      wf2 += int'(wf_pop2);
      if (state2 == 4'd1) capQ2.push_back(capture_col2);
    end
    if (rec4 && state4 != 4'd0) begin
      if (runS4.size() == 0 || runS4[runS4.size()-1] != int'(state4)) begin
        runS4.push_back(int'(state4));
        runL4.push_back(1);
        if (state4 == 4'd3) bufQ4.push_back(int'(buffer_select4));
      end else begin
        runL4[runL4.size()-1] = runL4[runL4.size()-1] + 1;
      end
    end
  endtask

  task automatic clearLogs();
    runS2.delete(); runL2.delete(); runS4.delete(); runL4.delete();
    bufQ4.delete(); capQ2.delete();
    mv2 = 0; ub2 = 0; rf2 = 0; lc2 = 0; wf2 = 0;
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] nl, input logic [4:0] nv);
    start       = st;
    num_layers  = nl;
    num_vectors = nv;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((busy2 || busy4) && n < 600) begin
      tick();
      n++;
    end
    checkOutput({tag, "_idleReached"}, 32'(!(busy2 || busy4)), 32'd1);
  endtask

  task automatic waitFor2(input logic [3:0] st, input int cnt, input string tag);
    int n = 0;
    while (!(state2 == st && (cnt < 0 || int'(cycle_cnt2) == cnt)) && n < 600) begin
      tick();
      n++;
    end
    checkOutput({tag, "_reached"}, 32'(state2 == st), 32'd1);
  endtask

  // Single-layer run on the ARRAY_N=2 instance: num_layers=1, num_vectors=2.
  task automatic runSingleN2(input string tag);
    int expS[5] = '{1, 2, 3, 4, 8};
    int expL[5] = '{3, 4, 3, 7, 9};
    clearLogs();
    applyStimulus(1'b1, 4'd1, 5'd2);
    rec2 = 1'b1;
    tick();
    start = 1'b0;
    waitIdle(tag);
    rec2 = 1'b0;
    checkOutput({tag, "_runCount"}, 32'(runS2.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < runS2.size()) begin
        checkOutput($sformatf("%s_state%0d", tag, i), 32'(runS2[i]), 32'(expS[i]));
        checkOutput($sformatf("%s_len%0d", tag, i), 32'(runL2[i]), 32'(expL[i]));
      end
    end
    checkOutput({tag, "_capCount"}, 32'(capQ2.size()), 32'd3);
    if (capQ2.size() == 3) begin
      checkOutput({tag, "_cap0"}, 32'(capQ2[0]), 32'd0);
      checkOutput({tag, "_cap1"}, 32'(capQ2[1]), 32'd1);
      checkOutput({tag, "_cap2"}, 32'(capQ2[2]), 32'd2);
    end
    checkOutput({tag, "_mmuValid"}, 32'(mv2), 32'd8);
    checkOutput({tag, "_ubRd"}, 32'(ub2), 32'd2);
    checkOutput({tag, "_refill"}, 32'(rf2), 32'd7);
    checkOutput({tag, "_layerDone"}, 32'(lc2), 32'd9);
    checkOutput({tag, "_wfPop"}, 32'(wf2), 32'd3);
    checkOutput({tag, "_finalLayer"}, 32'(current_layer2), 32'd0);
`ifdef MLP_SEQ_PERF_CNT_EN
    checkOutput({tag, "_perfTotal"}, perf_total2, 32'd26);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; abort = 1'b0; weights_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 5'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_state", 32'(state2), 32'd0);
    checkOutput("rst_busy", 32'(busy2), 32'd0);
    checkOutput("rst_cnt", 32'(cycle_cnt2), 32'd0);
    checkOutput("rst_layer", 32'(current_layer2), 32'd0);
    checkOutput("rst_bufsel", 32'(buffer_select2), 32'd0);
    checkOutput("rst_flags", 32'({cfg_err2, aborted2, mmu_valid2, wf_pop2}), 32'd0);

    runSingleN2("t1");

    // Three layers on the 4x4 instance with weights always ready.
    begin
      int expS[17] = '{1, 2, 3, 4, 5, 6, 7, 1, 3, 4, 5, 6, 7, 1, 3, 4, 8};
      int expL[17] = '{5, 6, 7, 11, 4, 1, 1, 5, 7, 11, 4, 1, 1, 5, 7, 11, 9};
      int waits = 0;
      clearLogs();
      weights_ready = 1'b1;
      applyStimulus(1'b1, 4'd3, 5'd4);
      rec4 = 1'b1;
      tick();
      start = 1'b0;
      waitIdle("t2");
      rec4 = 1'b0;
      checkOutput("t2_runCount", 32'(runS4.size()), 32'd17);
      for (int i = 0; i < 17; i++) begin
        if (i < runS4.size()) begin
          checkOutput($sformatf("t2_state%0d", i), 32'(runS4[i]), 32'(expS[i]));
          checkOutput($sformatf("t2_len%0d", i), 32'(runL4[i]), 32'(expL[i]));
          if (runS4[i] == 7) waits++;
        end
      end
      checkOutput("t2_waitVisits", 32'(waits), 32'd2);
      checkOutput("t2_bufCount", 32'(bufQ4.size()), 32'd3);
      if (bufQ4.size() == 3) begin
        checkOutput("t2_buf0", 32'(bufQ4[0]), 32'd0);
        checkOutput("t2_buf1", 32'(bufQ4[1]), 32'd1);
        checkOutput("t2_buf2", 32'(bufQ4[2]), 32'd0);
      end
      checkOutput("t2_finalLayer", 32'(current_layer4), 32'd2);
    end

    // Two layers with a 20-cycle weight stall on the 2x2 instance.
    begin
      int reqCnt = 0;
      weights_ready = 1'b0;
      applyStimulus(1'b1, 4'd2, 5'd2);
      tick();
      start = 1'b0;
      waitFor2(4'd7, -1, "t3_wait");
      repeat (20) begin
        if (weights_req2) reqCnt++;
        tick();
      end
      checkOutput("t3_reqCycles", 32'(reqCnt), 32'd20);
      checkOutput("t3_stillWait", 32'(state2), 32'd7);
      checkOutput("t3_cntAt20", 32'(cycle_cnt2), 32'd20);
      weights_ready = 1'b1;
      tick();
      checkOutput("t3_loadWeight", 32'(state2), 32'd1);
      checkOutput("t3_reqDrop", 32'(weights_req2), 32'd0);
`ifdef MLP_SEQ_PERF_CNT_EN
      checkOutput("t3_perfStall", perf_stall2, 32'd20);
`endif
      waitIdle("t3");
      checkOutput("t3_finalLayer", 32'(current_layer2), 32'd1);
`ifdef MLP_SEQ_PERF_CNT_EN
      checkOutput("t3_perfTotal", perf_total2, 32'd65);
`endif
    end

    // Rejected configurations.
    applyStimulus(1'b1, 4'd0, 5'd2);
    tick();
    checkOutput("t4_errLayers", 32'(cfg_err2), 32'd1);
    checkOutput("t4_busyLayers", 32'(busy2), 32'd0);
    start = 1'b0;
    tick();
    checkOutput("t4_errPulse", 32'(cfg_err2), 32'd0);
    applyStimulus(1'b1, 4'd1, 5'd17);
    tick();
    checkOutput("t4_errVectors", 32'(cfg_err2), 32'd1);
    checkOutput("t4_busyVectors", 32'(busy2), 32'd0);
    start = 1'b0;
    tick();
    checkOutput("t4_errPulse2", 32'(cfg_err2), 32'd0);
    checkOutput("t4_state", 32'(state2), 32'd0);

    // Abort in DRAIN at cnt 3, then abort-with-start in IDLE, then a clean rerun.
    applyStimulus(1'b1, 4'd1, 5'd2);
    tick();
    start = 1'b0;
    waitFor2(4'd4, 3, "t5_drain3");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t5_state", 32'(state2), 32'd0);
    checkOutput("t5_aborted", 32'(aborted2), 32'd1);
    checkOutput("t5_enables", 32'({mmu_valid2, accum_en2, refill_en2, ub_rd_ready2, wf_pop2,
                                   weights_req2, layer_complete2, busy2}), 32'd0);
    checkOutput("t5_abort4", 32'(state4), 32'd0);
`ifdef MLP_SEQ_PERF_CNT_EN
    checkOutput("t5_perfHold", perf_total2, 32'd14);
`endif
    tick();
    checkOutput("t5_abortPulse", 32'(aborted2), 32'd0);
    abort = 1'b1;
    applyStimulus(1'b1, 4'd1, 5'd2);
    tick();
    checkOutput("t5_idleAbortState", 32'(state2), 32'd0);
    checkOutput("t5_idleAbortPulse", 32'(aborted2), 32'd0);
    abort = 1'b0;
    start = 1'b0;
    tick();
    runSingleN2("t5_rerun");

    // Reset mid-COMPUTE with start held high throughout reset.
    applyStimulus(1'b1, 4'd1, 5'd2);
    tick();
    start = 1'b0;
    waitFor2(4'd3, -1, "t6_compute");
    reset = 1'b1;
    start = 1'b1;
    tick();
    checkOutput("t6_state", 32'(state2), 32'd0);
    checkOutput("t6_outs", 32'({busy2, mmu_valid2, ub_rd_ready2, wf_pop2, capture_col2}), 32'd0);
    checkOutput("t6_cnt", 32'(cycle_cnt2), 32'd0);
    tick();
    checkOutput("t6_startIgnored", 32'(state2), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("t6_afterRelease", 32'(busy2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
Parametrised multi-layer MLP control sequencer for an ARRAY_N x ARRAY_N systolic MMU. It drives weight-FIFO pop and per-column capture, unified-buffer ping-pong select and read/refill enables, accumulator valid/enable, and layer bookkeeping. It supports a runtime layer count and vector count, a weight-ready handshake between layers, and abort. It replaces the fixed 2x2, fixed-layer-count FSM inside the top-level MLP integration and sits beside the datapath it controls.

Parameters:
ARRAY_N, 2, systolic array dimension (columns = rows); legal range 2..16
MAX_LAYERS, 8, maximum layer count; LAYER_W = $clog2(MAX_LAYERS+1)
MAX_VEC, 16, maximum activation vectors per layer; VEC_W = $clog2(MAX_VEC+1)
XFER_CYCLES, 4, TRANSFER state length in cycles; must be >= 1
DONE_HOLD, 9, cycles spent in DONE; must be >= 1

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  start pulse; sampled only in IDLE
abort  in  1  synchronous abort; any state -> IDLE
num_layers  in  LAYER_W  layer count; latched on accepted start
num_vectors  in  VEC_W  vectors per layer; latched on accepted start
weights_ready  in  1  next layer's weights are in the FIFO
weights_req  out  1  high in WAIT_WEIGHTS
wf_pop  out  1  weight FIFO pop; high throughout LOAD_WEIGHT
capture_col  out  ARRAY_N  one-hot column weight capture
ub_rd_ready  out  1  activation read strobe for the active buffer
buffer_select  out  1  active read buffer: 0 = A, 1 = B
refill_en  out  1  write window for the inactive buffer
mmu_valid  out  1  accumulator valid_in
accum_en  out  1  accumulator accumulate enable
state  out  4  encoded FSM state
cycle_cnt  out  CNT_W  in-state counter; CNT_W = $clog2(MAX_VEC+2*ARRAY_N+4)
current_layer  out  LAYER_W  zero-based layer index
layer_complete  out  1  high in DONE
busy  out  1  state != IDLE
cfg_err  out  1  1-cycle pulse on start rejected for a bad config
aborted  out  1  1-cycle pulse on abort taken

Behaviour:
- Reset is synchronous and active-high. On reset: state = IDLE; all counters, latched configuration and outputs are 0.
- State encoding: IDLE=0, LOAD_WEIGHT=1, LOAD_ACT=2, COMPUTE=3, DRAIN=4, TRANSFER=5, NEXT_LAYER=6, WAIT_WEIGHTS=7, DONE=8. cycle_cnt clears to 0 on every state change.
- IDLE: on start, with num_layers in 1..MAX_LAYERS and num_vectors in 1..MAX_VEC -> LOAD_WEIGHT; latch the config; current_layer = 0; buffer_select = 0. Otherwise pulse cfg_err and stay in IDLE.
- LOAD_WEIGHT: lasts ARRAY_N+1 cycles (cnt 0..ARRAY_N). capture_col[k] = 1 when cnt == k+1. At cnt == ARRAY_N: go to LOAD_ACT if layer 0, else COMPUTE.
- LOAD_ACT: lasts ARRAY_N+2 cycles -> COMPUTE.
- COMPUTE: lasts num_vectors+ARRAY_N-1 cycles. ub_rd_ready = 1 while cnt < num_vectors. mmu_valid = 1 while cnt >= ARRAY_N. At the last cycle -> DRAIN.
- DRAIN: lasts 2*ARRAY_N+3 cycles. mmu_valid = 1 throughout. accum_en = 1 for cnt >= 1. At the last cycle: go to TRANSFER if current_layer < num_layers-1, else DONE.
- refill_en = 1 in DRAIN and TRANSFER. Refill always targets the inactive buffer (~buffer_select).
- TRANSFER: lasts XFER_CYCLES cycles -> NEXT_LAYER.
- NEXT_LAYER: single cycle. Toggles buffer_select, increments current_layer -> WAIT_WEIGHTS.
- WAIT_WEIGHTS: weights_req = 1. On weights_ready -> LOAD_WEIGHT. If weights_ready is already high on entry, exactly one cycle is spent here.
- DONE: layer_complete = 1 for DONE_HOLD cycles, then IDLE. current_layer holds the final index until the next accepted start.
- abort: has priority over every transition. Any non-IDLE state -> IDLE next cycle with aborted pulsed. Abort in IDLE is a no-op with no pulse. Abort and start together in IDLE: abort wins and start is ignored.
- start is ignored outside IDLE.
- Latched config is stable for the whole run; input changes mid-run have no effect.

Optional Feature:
Macro MLP_SEQ_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_total_cycles (busy cycles of the last run) and perf_stall_cycles (cycles in WAIT_WEIGHTS with weights_ready = 0). Both clear on accepted start and saturate at 0xFFFFFFFF. Both hold after DONE or abort.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mlp_pkg holds: the state enum typedef (4-bit), the state encodings, and localparam helper functions for per-state durations (load_w_len, load_act_len, compute_len, drain_len).
- One natural sub-module, mlp_phase_counter: a loadable, clear-on-transition cycle counter with a terminal-count compare, instantiated once.

Test Plan:
- ARRAY_N=2, num_layers=1, num_vectors=2, start -> state sequence 1,2,3,4,8,0. Durations 3,4,3,7,9 cycles. capture_col = 01 then 10. mmu_valid high for 8 cycles total.
- ARRAY_N=4, num_layers=3, num_vectors=4, weights_ready tied high -> LOAD_ACT only in layer 0. buffer_select reads 0,1,0. Exactly 2 WAIT_WEIGHTS visits of 1 cycle each. Final current_layer = 2.
- num_layers=2, weights_ready held low 20 cycles after WAIT_WEIGHTS entry -> weights_req high 20 cycles, then LOAD_WEIGHT. With the macro defined, perf_stall_cycles = 20.
- start with num_layers=0 and, separately, num_vectors=MAX_VEC+1 -> cfg_err one-cycle pulse each time; busy stays 0.
- abort asserted at DRAIN cnt=3 -> state 0 next cycle, aborted pulse, every enable 0. A subsequent start runs a clean full sequence.
- reset asserted mid-COMPUTE -> all outputs 0 on the next cycle; start held high during reset is not accepted.
